// File: rtl/dmem_pkg.sv
// Shared definitions for the MEM-stage data memory: funct3 codes, FSM states
// and byte-enable generation.
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {ST_IDLE, ST_WAIT} state_t;

  // size is funct3[1:0]; lane is addr[1:0]
  function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      2'b00:   byte_en = 4'b0001 << lane;
      2'b01:   byte_en = lane[1] ? 4'b1100 : 4'b0011;
      default: byte_en = 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word storage with asynchronous read and byte-enabled synchronous write; no reset.
module dmem_array #(
  parameter int unsigned DEPTH_WORDS = 256
) (
  input  logic                           clk,
  input  logic                           we,
  input  logic [3:0]                     be,
  input  logic [$clog2(DEPTH_WORDS)-1:0] idx,
  input  logic [31:0]                    wdata,
  output logic [31:0]                    rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  assign rdata = mem[idx];

endmodule

// File: rtl/dmem_unit.sv
// MEM-stage data memory responder: wait-state FSM, legality/alignment check,
// load extension and sticky fault flag around a byte-enabled word array.
module dmem_unit
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memread,
  input  logic        memwrite,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        fault,
  output logic        fault_sticky
);

  localparam int unsigned AW       = $clog2(DEPTH_WORDS);
  localparam int unsigned CW       = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam bit          HAS_WAIT = (WAIT_CYCLES != 0);

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          req, done, f3_legal, aligned, bad, we;
  logic [3:0]    be;
  logic [31:0]   wword, rword, shifted, load_val;
  logic          unused_hi_addr;

  assign req            = memread | memwrite;
  assign unused_hi_addr = ^addr[31:AW+2];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      ST_IDLE: begin
        if (req && HAS_WAIT) begin
          state_nxt = ST_WAIT;
          cnt_nxt   = CW'(WAIT_CYCLES - 1);
        end
      end
      ST_WAIT: begin
        if (cnt == '0) state_nxt = ST_IDLE;
        else           cnt_nxt   = cnt - CW'(1);
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Stall is gated by rst so it drops immediately even while strobes are held.
  always_comb begin
    stall = 1'b0;
    done  = 1'b0;
    if (!rst) begin
      stall = ((state == ST_IDLE) && req && HAS_WAIT) ||
              ((state == ST_WAIT) && (cnt != '0));
      done  = req && (((state == ST_IDLE) && !HAS_WAIT) ||
                      ((state == ST_WAIT) && (cnt == '0)));
    end
  end

  always_comb begin
    f3_legal = 1'b0;
    if (memread && !memwrite)
      f3_legal = funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
    else if (memwrite && !memread)
      f3_legal = funct3 inside {F3_B, F3_H, F3_W};
  end

  assign aligned = (funct3[1:0] == 2'b00) ||
                   ((funct3[1:0] == 2'b01) && !addr[0]) ||
                   ((funct3[1:0] == 2'b10) && (addr[1:0] == 2'b00));
  assign bad     = !f3_legal || !aligned;
  assign fault   = done && bad;

  always_comb begin
    case (funct3[1:0])
      2'b00:   wword = {4{wdata[7:0]}};
      2'b01:   wword = {2{wdata[15:0]}};
      default: wword = wdata;
    endcase
  end

  assign be = byte_en(funct3[1:0], addr[1:0]);
  assign we = done && memwrite && !memread && !bad;

  dmem_array #(.DEPTH_WORDS(DEPTH_WORDS)) u_array (
    .clk   (clk),
    .we    (we),
    .be    (be),
    .idx   (addr[AW+1:2]),
    .wdata (wword),
    .rdata (rword)
  );

  assign shifted = rword >> {addr[1:0], 3'b000};

  always_comb begin
    case (funct3)
      F3_B:    load_val = {{24{shifted[7]}}, shifted[7:0]};
      F3_BU:   load_val = {24'h0, shifted[7:0]};
      F3_H:    load_val = {{16{shifted[15]}}, shifted[15:0]};
      F3_HU:   load_val = {16'h0, shifted[15:0]};
      default: load_val = rword;
    endcase
  end

  assign rdata = (done && memread && !bad) ? load_val : 32'h0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        fault_sticky <= 1'b0;
    else if (fault) fault_sticky <= 1'b1;
  end

endmodule

// File: tb/tb_dmem_unit.sv
// Bench for dmem_unit: a zero-wait and a two-wait instance checked against a
// byte-addressed reference memory with directed and random accesses.
module tb_dmem_unit;
  import dmem_pkg::*;

  localparam int unsigned DEPTH = 64;
  localparam int unsigned NB    = DEPTH * 4;
  localparam int unsigned W0    = 0;
  localparam int unsigned W1    = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        mr [2];
  logic        mw [2];
  logic [2:0]  f3 [2];
  logic [31:0] ad [2];
  logic [31:0] wd [2];
  logic [31:0] rd [2];
  logic        st [2];
  logic        ft [2];
  logic        fs [2];

  logic [7:0]  mb [2][NB];
  bit          sticky [2];
  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] got;

  always #5 clk = ~clk;

  dmem_unit #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(W0)) dut0 (
    .clk(clk), .rst(rst), .memread(mr[0]), .memwrite(mw[0]), .funct3(f3[0]),
    .addr(ad[0]), .wdata(wd[0]), .rdata(rd[0]), .stall(st[0]), .fault(ft[0]),
    .fault_sticky(fs[0]));

  dmem_unit #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(W1)) dut1 (
    .clk(clk), .rst(rst), .memread(mr[1]), .memwrite(mw[1]), .funct3(f3[1]),
    .addr(ad[1]), .wdata(wd[1]), .rdata(rd[1]), .stall(st[1]), .fault(ft[1]),
    .fault_sticky(fs[1]));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit exp_fault(bit r, bit w, logic [2:0] f, logic [31:0] a);
    int sz;
    if (r && w) return 1'b1;
    if (!r && !w) return 1'b0;
    if (f == 3'b011 || f == 3'b110 || f == 3'b111) return 1'b1;
    if (w && f[2]) return 1'b1;
    sz = 1 << f[1:0];
    return (a & 32'(sz - 1)) != 0;
  endfunction

  function automatic logic [31:0] model_load(int u, logic [2:0] f, logic [31:0] a);
    int base = int'(a & 32'(NB - 1));
    int sz   = 1 << f[1:0];
    logic [31:0] v = 32'h0;
    for (int i = 0; i < sz; i++) v |= 32'(mb[u][base + i]) << (8 * i);
    if (!f[2] && sz < 4 && v[8*sz-1]) v |= ~((32'd1 << (8 * sz)) - 32'd1);
    return v;
  endfunction

  task automatic model_store(int u, logic [2:0] f, logic [31:0] a, logic [31:0] d);
    int base = int'(a & 32'(NB - 1));
    int sz   = 1 << f[1:0];
    for (int i = 0; i < sz; i++) mb[u][base + i] = d[8*i +: 8];
  endtask

  // Issues one access starting just after a rising edge; returns the observed rdata.
  task automatic access(input int u, input bit r, input bit w, input logic [2:0] f,
                        input logic [31:0] a, input logic [31:0] d, output logic [31:0] obs);
    bit          ef;
    logic [31:0] er;
    int          wc = (u == 0) ? int'(W0) : int'(W1);
    ef = exp_fault(r, w, f, a);
    er = (r && !ef) ? model_load(u, f, a) : 32'h0;
    mr[u] = r; mw[u] = w; f3[u] = f; ad[u] = a; wd[u] = d;
    for (int k = 0; k < wc; k++) begin
      @(negedge clk);
      check("stall_busy", 32'(st[u]), 32'd1);
      check("fault_busy", 32'(ft[u]), 32'd0);
      @(posedge clk); #1;
    end
    @(negedge clk);
    check("stall_done", 32'(st[u]), 32'd0);
    check("fault", 32'(ft[u]), 32'(ef));
    check("rdata", rd[u], er);
    check("sticky", 32'(fs[u]), 32'(sticky[u]));
    obs = rd[u];
    if (w && !r && !ef) model_store(u, f, a, d);
    if (ef) sticky[u] = 1'b1;
    @(posedge clk); #1;
    mr[u] = 1'b0; mw[u] = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      for (int u = 0; u < 2; u++) begin
        check("idle_stall", 32'(st[u]), 32'd0);
        check("idle_fault", 32'(ft[u]), 32'd0);
        check("idle_rdata", rd[u], 32'h0);
        check("idle_sticky", 32'(fs[u]), 32'(sticky[u]));
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    rst = 1'b1;
    for (int u = 0; u < 2; u++) begin
      mr[u] = 1'b0; mw[u] = 1'b0; f3[u] = 3'b0; ad[u] = 32'h0; wd[u] = 32'h0;
      sticky[u] = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int u = 0; u < 2; u++) begin
      check("rst_stall", 32'(st[u]), 32'd0);
      check("rst_fault", 32'(ft[u]), 32'd0);
      check("rst_rdata", rd[u], 32'h0);
      check("rst_sticky", 32'(fs[u]), 32'd0);
    end
    rst = 1'b0;

    for (int u = 0; u < 2; u++)
      for (int i = 0; i < int'(DEPTH); i++)
        access(u, 1'b0, 1'b1, F3_W, 32'(i * 4), $urandom, got);

    // Zero-wait instance
    access(0, 1'b0, 1'b1, F3_W, 32'h10, 32'hDEADBEEF, got);
    access(0, 1'b1, 1'b0, F3_W, 32'h10, 32'h0, got);
    check("w0_lw", got, 32'hDEADBEEF);

    // Two-wait instance: lane extraction and extension
    access(1, 1'b0, 1'b1, F3_W, 32'h10, 32'h80FF7F01, got);
    access(1, 1'b1, 1'b0, F3_B, 32'h13, 32'h0, got);
    check("lb_13", got, 32'hFFFFFF80);
    access(1, 1'b1, 1'b0, F3_BU, 32'h13, 32'h0, got);
    check("lbu_13", got, 32'h00000080);
    access(1, 1'b1, 1'b0, F3_H, 32'h10, 32'h0, got);
    check("lh_10", got, 32'h00007F01);
    access(1, 1'b1, 1'b0, F3_HU, 32'h12, 32'h0, got);
    check("lhu_12", got, 32'h000080FF);
    access(1, 1'b1, 1'b0, F3_W, 32'h12345010, 32'h0, got);
    check("lw_wrap", got, 32'h80FF7F01);

    access(1, 1'b0, 1'b1, F3_W, 32'h20, 32'h11223344, got);
    access(1, 1'b0, 1'b1, F3_B, 32'h21, 32'h000000AA, got);
    access(1, 1'b1, 1'b0, F3_W, 32'h20, 32'h0, got);
    check("sb_merge", got, 32'h1122AA44);

    // Faulting accesses must leave the array alone
    access(1, 1'b0, 1'b1, F3_W, 32'h30, 32'hCAFEF00D, got);
    access(1, 1'b1, 1'b0, F3_W, 32'h22, 32'h0, got);
    access(1, 1'b0, 1'b1, F3_H, 32'h31, 32'h0000BEEF, got);
    access(1, 1'b1, 1'b0, 3'b011, 32'h30, 32'h0, got);
    access(1, 1'b1, 1'b1, F3_W, 32'h30, 32'h0, got);
    access(1, 1'b0, 1'b1, 3'b011, 32'h30, 32'h0, got);
    access(1, 1'b1, 1'b0, F3_W, 32'h30, 32'h0, got);
    check("fault_nowrite", got, 32'hCAFEF00D);
    idle(2);
    check("sticky_held", 32'(fs[1]), 32'd1);

    // Reset during the second stall cycle of a store
    mr[1] = 1'b0; mw[1] = 1'b1; f3[1] = F3_W; ad[1] = 32'h40; wd[1] = 32'h55AA55AA;
    @(posedge clk); #1;
    check("mid_stall", 32'(st[1]), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("rst_async_stall", 32'(st[1]), 32'd0);
    check("rst_async_sticky", 32'(fs[1]), 32'd0);
    #1 rst = 1'b0;
    mw[1] = 1'b0;
    sticky[0] = 1'b0; sticky[1] = 1'b0;
    @(posedge clk); #1;
    access(1, 1'b1, 1'b0, F3_W, 32'h40, 32'h0, got);

    // Random traffic, back-to-back with occasional bubbles
    for (int n = 0; n < 400; n++) begin
      int          u;
      int          sel;
      int          sz;
      bit          r, w;
      logic [2:0]  f;
      logic [31:0] a;
      logic [2:0]  legal [5];
      legal[0] = F3_B; legal[1] = F3_H; legal[2] = F3_W; legal[3] = F3_BU; legal[4] = F3_HU;
      u   = int'($urandom_range(0, 1));
      sel = int'($urandom_range(0, 15));
      r   = (sel <= 8);
      w   = (sel == 0) || (sel > 8);
      if ($urandom_range(0, 7) == 0) f = 3'($urandom_range(0, 7));
      else if (w && !r)              f = legal[$urandom_range(0, 2)];
      else                           f = legal[$urandom_range(0, 4)];
      a  = $urandom;
      sz = 1 << f[1:0];
      if ($urandom_range(0, 3) != 0) a &= ~32'(sz - 1);
      access(u, r, w, f, a, $urandom, got);
      if ($urandom_range(0, 4) == 0) idle(1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
